// File: rtl/crtc_reg_ctrl.sv
// 6845-style CRTC register file: CPU writes land in a shadow bank that is committed to the live timing bank at vsync rise.
// Optional CRTC_READBACK_EN enables data-register reads of R12..R17; otherwise cpu_data_o is tied to zero.
module crtc_reg_ctrl #(
    parameter bit COMMIT_ON_VSYNC = 1'b1,
    parameter int NUM_REGS        = 18
) (
    input  logic        reset_i,
    input  logic        cclk_i,
    input  logic        cpu_cs_i,
    input  logic        cpu_rs_i,
    input  logic        cpu_we_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    input  logic        v_sync_i,
    output logic        pending_o,
    output logic [7:0]  h_total_o,
    output logic [7:0]  h_displayed_o,
    output logic [7:0]  h_sync_pos_o,
    output logic [7:0]  sync_width_o,
    output logic [6:0]  v_total_o,
    output logic [4:0]  v_total_adj_o,
    output logic [6:0]  v_displayed_o,
    output logic [6:0]  v_sync_pos_o,
    output logic [4:0]  max_scan_line_o,
    output logic [13:0] start_addr_o
);

    // state   | meaning
    // IDLE    | shadow and live banks match
    // PENDING | shadow holds writes waiting for the next vsync rise
    typedef enum logic {IDLE, PENDING} state_t;

    state_t      state_q, state_d;
    logic [4:0]  addr_q;
    logic [7:0]  shadow [NUM_REGS];
    logic        v_sync_q;
    logic        vsync_rise;
    logic        data_wr;
    logic        commit;

    function automatic logic [7:0] reg_default(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'd63;
            5'd1:    return 8'd40;
            5'd2:    return 8'd48;
            5'd3:    return 8'h15;
            5'd4:    return 8'd32;
            5'd6:    return 8'd25;
            5'd7:    return 8'd28;
            5'd9:    return 8'd7;
            5'd12:   return 8'h10;
            default: return 8'h00;
        endcase
    endfunction

    // R16/R17 are read-only light-pen registers: a zero mask marks them unwritable.
    function automatic logic [7:0] reg_mask(input logic [4:0] idx);
        case (idx)
            5'd4, 5'd6, 5'd7, 5'd10: return 8'h7F;
            5'd5, 5'd9, 5'd11:       return 8'h1F;
            5'd12, 5'd14:            return 8'h3F;
            5'd16, 5'd17:            return 8'h00;
            default:                 return 8'hFF;
        endcase
    endfunction

    assign vsync_rise = v_sync_i & ~v_sync_q;
    assign data_wr    = cpu_cs_i & cpu_we_i & cpu_rs_i & (int'(addr_q) < NUM_REGS)
                        & (reg_mask(addr_q) != 8'h00);

    always_comb begin
        state_d = state_q;
        commit  = 1'b0;
        if (COMMIT_ON_VSYNC) begin
            case (state_q)
                IDLE: begin
                    if (data_wr) state_d = PENDING;
                end
                PENDING: begin
                    if (vsync_rise) begin
                        commit  = 1'b1;
                        state_d = data_wr ? PENDING : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else begin
            state_d = IDLE;
            commit  = 1'b1;
        end
    end

    always_ff @(posedge cclk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            v_sync_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) shadow[i] <= reg_default(5'(i));
        end else begin
            state_q  <= state_d;
            v_sync_q <= v_sync_i;
            if (cpu_cs_i & cpu_we_i & ~cpu_rs_i) addr_q <= cpu_data_i[4:0];
            if (data_wr) shadow[addr_q] <= cpu_data_i & reg_mask(addr_q);
        end
    end

    assign pending_o = (state_q == PENDING);

    // Live bank samples the pre-write shadow, so a write coincident with commit waits a frame.
    always_ff @(posedge cclk_i or posedge reset_i) begin
        if (reset_i) begin
            h_total_o       <= 8'd63;
            h_displayed_o   <= 8'd40;
            h_sync_pos_o    <= 8'd48;
            sync_width_o    <= 8'h15;
            v_total_o       <= 7'd32;
            v_total_adj_o   <= 5'd0;
            v_displayed_o   <= 7'd25;
            v_sync_pos_o    <= 7'd28;
            max_scan_line_o <= 5'd7;
            start_addr_o    <= 14'h1000;
        end else if (commit) begin
            h_total_o       <= shadow[0];
            h_displayed_o   <= shadow[1];
            h_sync_pos_o    <= shadow[2];
            sync_width_o    <= shadow[3];
            v_total_o       <= shadow[4][6:0];
            v_total_adj_o   <= shadow[5][4:0];
            v_displayed_o   <= shadow[6][6:0];
            v_sync_pos_o    <= shadow[7][6:0];
            max_scan_line_o <= shadow[9][4:0];
            start_addr_o    <= {shadow[12][5:0], shadow[13]};
        end
    end

`ifdef CRTC_READBACK_EN
    always_ff @(posedge cclk_i or posedge reset_i) begin
        if (reset_i) begin
            cpu_data_o <= 8'h00;
        end else if (cpu_cs_i & ~cpu_we_i) begin
            if (cpu_rs_i && addr_q >= 5'd12 && int'(addr_q) < NUM_REGS)
                cpu_data_o <= shadow[addr_q];
            else
                cpu_data_o <= 8'h00;
        end
    end
`else
    assign cpu_data_o = 8'h00;
`endif

endmodule

// File: tb/tb_crtc_reg_ctrl.sv
// Directed bench for crtc_reg_ctrl: a vsync-commit instance and a follow-through instance share one CPU bus.
module tb_crtc_reg_ctrl;

    logic        reset_i = 1'b1;
    logic        cclk_i  = 1'b0;
    logic        cpu_cs_i = 1'b0, cpu_rs_i = 1'b0, cpu_we_i = 1'b0;
    logic [7:0]  cpu_data_i = '0;
    logic        v_sync_i = 1'b0;

    logic [7:0]  data_a, data_b;
    logic        pend_a, pend_b;
    logic [7:0]  ht_a, hd_a, hs_a, sw_a, ht_b, hd_b, hs_b, sw_b;
    logic [6:0]  vt_a, vd_a, vs_a, vt_b, vd_b, vs_b;
    logic [4:0]  va_a, ms_a, va_b, ms_b;
    logic [13:0] sa_a, sa_b;

    int n_checks = 0;
    int n_pass   = 0;

    always #500 cclk_i = ~cclk_i;

    crtc_reg_ctrl #(.COMMIT_ON_VSYNC(1'b1)) dut_a (
        .reset_i(reset_i), .cclk_i(cclk_i), .cpu_cs_i(cpu_cs_i), .cpu_rs_i(cpu_rs_i),
        .cpu_we_i(cpu_we_i), .cpu_data_i(cpu_data_i), .cpu_data_o(data_a), .v_sync_i(v_sync_i),
        .pending_o(pend_a), .h_total_o(ht_a), .h_displayed_o(hd_a), .h_sync_pos_o(hs_a),
        .sync_width_o(sw_a), .v_total_o(vt_a), .v_total_adj_o(va_a), .v_displayed_o(vd_a),
        .v_sync_pos_o(vs_a), .max_scan_line_o(ms_a), .start_addr_o(sa_a));

    crtc_reg_ctrl #(.COMMIT_ON_VSYNC(1'b0)) dut_b (
        .reset_i(reset_i), .cclk_i(cclk_i), .cpu_cs_i(cpu_cs_i), .cpu_rs_i(cpu_rs_i),
        .cpu_we_i(cpu_we_i), .cpu_data_i(cpu_data_i), .cpu_data_o(data_b), .v_sync_i(v_sync_i),
        .pending_o(pend_b), .h_total_o(ht_b), .h_displayed_o(hd_b), .h_sync_pos_o(hs_b),
        .sync_width_o(sw_b), .v_total_o(vt_b), .v_total_adj_o(va_b), .v_displayed_o(vd_b),
        .v_sync_pos_o(vs_b), .max_scan_line_o(ms_b), .start_addr_o(sa_b));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One-cclk bus access; returns on the falling edge after the sampling edge.
    task automatic access(input logic rs, input logic we, input logic [7:0] d);
        @(negedge cclk_i);
        cpu_cs_i = 1'b1; cpu_rs_i = rs; cpu_we_i = we; cpu_data_i = d;
        @(negedge cclk_i);
        cpu_cs_i = 1'b0; cpu_we_i = 1'b0; cpu_rs_i = 1'b0; cpu_data_i = '0;
    endtask

    task automatic vsync_pulse();
        @(negedge cclk_i);
        v_sync_i = 1'b1;
        @(negedge cclk_i);
        v_sync_i = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge cclk_i);
        check("rst_pending", {31'b0, pend_a}, 32'd0);
        reset_i = 1'b0;
        @(negedge cclk_i);
        check("rst_r0", ht_a, 32'd63);
        check("rst_r1", hd_a, 32'd40);
        check("rst_r2", hs_a, 32'd48);
        check("rst_r3", sw_a, 32'h15);
        check("rst_r4", vt_a, 32'd32);
        check("rst_r6", vd_a, 32'd25);
        check("rst_r7", vs_a, 32'd28);
        check("rst_r9", ms_a, 32'd7);
        check("rst_start", sa_a, 32'h1000);
        check("rst_data", data_a, 32'd0);
        check("rst_pending_run", {31'b0, pend_a}, 32'd0);

        // R1=80 is held in shadow until a vsync rise
        access(1'b0, 1'b1, 8'd1);
        access(1'b1, 1'b1, 8'd80);
        repeat (1000) @(negedge cclk_i);
        check("r1_held", hd_a, 32'd40);
        check("r1_pending", {31'b0, pend_a}, 32'd1);
        vsync_pulse();
        check("r1_commit", hd_a, 32'd80);
        check("r1_pending_clr", {31'b0, pend_a}, 32'd0);

        vsync_pulse();
        check("idle_vsync_r1", hd_a, 32'd80);
        check("idle_vsync_pend", {31'b0, pend_a}, 32'd0);

        // R4 masked to 7 bits
        access(1'b0, 1'b1, 8'd4);
        access(1'b1, 1'b1, 8'hFF);
        vsync_pulse();
        check("r4_mask", vt_a, 32'h7F);

        // Out-of-range address 20 and read-only R16: no effect
        access(1'b0, 1'b1, 8'd20);
        access(1'b1, 1'b1, 8'h12);
        check("oor_no_pend", {31'b0, pend_a}, 32'd0);
        access(1'b0, 1'b1, 8'd16);
        access(1'b1, 1'b1, 8'h12);
        check("ro_no_pend", {31'b0, pend_a}, 32'd0);
        vsync_pulse();
        check("oor_r4", vt_a, 32'h7F);
        check("oor_r5", va_a, 32'd0);

        // Address 0x25 keeps only bits [4:0] -> R5
        access(1'b0, 1'b1, 8'h25);
        access(1'b1, 1'b1, 8'h12);
        vsync_pulse();
        check("addr_trunc_r5", va_a, 32'h12);

        // Rewriting an identical value still marks pending
        access(1'b0, 1'b1, 8'd6);
        access(1'b1, 1'b1, 8'd25);
        check("same_val_pend", {31'b0, pend_a}, 32'd1);

        // R7=30 written on the same edge as vsync rise: lands one frame later
        access(1'b0, 1'b1, 8'd7);
        @(negedge cclk_i);
        cpu_cs_i = 1'b1; cpu_rs_i = 1'b1; cpu_we_i = 1'b1; cpu_data_i = 8'd30;
        v_sync_i = 1'b1;
        @(negedge cclk_i);
        cpu_cs_i = 1'b0; cpu_rs_i = 1'b0; cpu_we_i = 1'b0; cpu_data_i = '0;
        v_sync_i = 1'b0;
        check("coinc_r7_old", vs_a, 32'd28);
        check("coinc_pend", {31'b0, pend_a}, 32'd1);
        repeat (5) @(negedge cclk_i);
        vsync_pulse();
        check("coinc_r7_new", vs_a, 32'd30);
        check("coinc_pend_clr", {31'b0, pend_a}, 32'd0);

        // Read path
        access(1'b0, 1'b1, 8'd13);
        access(1'b1, 1'b1, 8'h5A);
        access(1'b1, 1'b0, 8'h00);
`ifdef CRTC_READBACK_EN
        check("read_r13", data_a, 32'h5A);
`else
        check("read_r13_off", data_a, 32'h00);
`endif
        access(1'b0, 1'b1, 8'd0);
        access(1'b1, 1'b0, 8'h00);
        check("read_r0", data_a, 32'h00);
        access(1'b0, 1'b0, 8'h00);
        check("read_addr", data_a, 32'h00);

        // Reset while pending
        access(1'b0, 1'b1, 8'd1);
        access(1'b1, 1'b1, 8'd99);
        check("pre_rst_pend", {31'b0, pend_a}, 32'd1);
        #200 reset_i = 1'b1;
        #1;
        check("rst_async_pend", {31'b0, pend_a}, 32'd0);
        check("rst_async_r1", hd_a, 32'd40);
        check("rst_async_r4", vt_a, 32'd32);
        @(negedge cclk_i);
        reset_i = 1'b0;

        // Follow-through instance: live tracks shadow one cclk later
        access(1'b0, 1'b1, 8'd2);
        access(1'b1, 1'b1, 8'd50);
        check("bypass_r2_early", hs_b, 32'd48);
        check("bypass_pend_a", {31'b0, pend_a}, 32'd1);
        @(negedge cclk_i);
        check("bypass_r2", hs_b, 32'd50);
        check("bypass_pend", {31'b0, pend_b}, 32'd0);
        check("vsync_r2_held", hs_a, 32'd48);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
